// File: rtl/drain_collector.sv
// Drain-channel collector: per-PE holding slots, round-robin arbiter, result FIFO.
// Optional macro DRAIN_IDX_EN stores the source PE index with each result (res_idx_o).
module drain_collector #(
   parameter int unsigned NUM_PE     = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DATA_WIDTH = 16,
   localparam int unsigned IDX_W     = $clog2(NUM_PE),
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                clear_i,
   // Each element is a packed drain_data_t: {data[DATA_WIDTH-1:0], enable}
   input  logic [NUM_PE-1:0][DATA_WIDTH:0]     drain_i,
   output logic                                res_valid_o,
   input  logic                                res_ready_i,
   output logic [DATA_WIDTH-1:0]               res_data_o,
`ifdef DRAIN_IDX_EN
   output logic [IDX_W-1:0]                    res_idx_o,
`endif
   output logic [CNT_W-1:0]                    fifo_count_o,
   output logic                                overflow_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
`ifdef DRAIN_IDX_EN
   localparam int unsigned ENTRY_W = DATA_WIDTH + IDX_W;
`else
   localparam int unsigned ENTRY_W = DATA_WIDTH;
`endif

   logic [NUM_PE-1:0]                  r_slot_vld;
   logic [NUM_PE-1:0][DATA_WIDTH-1:0]  r_slot_data;
   logic [IDX_W-1:0]                   r_ptr;
   logic [ENTRY_W-1:0]                 r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]                   r_wptr;
   logic [PTR_W-1:0]                   r_rptr;
   logic [CNT_W-1:0]                   r_count;
   logic                               r_ovf;

   logic                               w_pop;
   logic                               w_full;
   logic                               w_can_push;
   logic                               w_gnt_any;
   logic [IDX_W-1:0]                   w_gnt_idx;
   logic [NUM_PE-1:0]                  w_gnt;
   logic [ENTRY_W-1:0]                 w_push_entry;
   logic [ENTRY_W-1:0]                 w_head;

   assign w_pop      = (r_count != '0) && res_ready_i && !clear_i;
   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign w_can_push = !clear_i && (!w_full || w_pop);

   always_comb begin
      int unsigned j;
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      j         = 0;
      for (int unsigned k = 0; k < NUM_PE; k++) begin
         j = (32'(r_ptr) + k) % NUM_PE;
         if (!w_gnt_any && r_slot_vld[j]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = IDX_W'(j);
         end
      end
      if (!w_can_push) begin
         w_gnt_any = 1'b0;
      end
      w_gnt = w_gnt_any ? (NUM_PE'(1) << w_gnt_idx) : '0;
   end

`ifdef DRAIN_IDX_EN
   assign w_push_entry = {w_gnt_idx, r_slot_data[w_gnt_idx]};
`else
   assign w_push_entry = r_slot_data[w_gnt_idx];
`endif

   // Holding slots, sticky overflow and round-robin pointer
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_slot_vld  <= '0;
         r_slot_data <= '0;
         r_ptr       <= '0;
         r_ovf       <= 1'b0;
      end else if (clear_i) begin
         r_slot_vld  <= '0;
         r_slot_data <= '0;
         r_ptr       <= '0;
         r_ovf       <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (drain_i[i][0]) begin
               if (!r_slot_vld[i] || w_gnt[i]) begin
                  r_slot_vld[i]  <= 1'b1;
                  r_slot_data[i] <= drain_i[i][DATA_WIDTH:1];
               end else begin
                  r_ovf <= 1'b1;
               end
            end else if (w_gnt[i]) begin
               r_slot_vld[i] <= 1'b0;
            end
         end
         if (w_gnt_any) begin
            r_ptr <= (w_gnt_idx == IDX_W'(NUM_PE - 1)) ? '0 : w_gnt_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (clear_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_gnt_any) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_gnt_any && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_gnt_any && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Storage needs no reset: outputs are gated by the occupancy count
   always_ff @(posedge clk_i) begin
      if (w_gnt_any) begin
         r_mem[r_wptr] <= w_push_entry;
      end
   end

   assign w_head       = r_mem[r_rptr];
   assign res_valid_o  = (r_count != '0);
   assign res_data_o   = res_valid_o ? w_head[DATA_WIDTH-1:0] : '0;
`ifdef DRAIN_IDX_EN
   assign res_idx_o    = res_valid_o ? w_head[ENTRY_W-1:DATA_WIDTH] : '0;
`endif
   assign fifo_count_o = r_count;
   assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_drain_collector.sv
// Self-checking bench for drain_collector: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_drain_collector;

   localparam int NPE   = 4;
   localparam int DEPTH = 8;
   localparam int DW    = 16;

   logic                    clk;
   logic                    rst_n;
   logic                    clear;
   logic [NPE-1:0][DW:0]    drain;
   logic                    res_valid;
   logic                    ready;
   logic [DW-1:0]           res_data;
`ifdef DRAIN_IDX_EN
   logic [1:0]              res_idx;
`endif
   logic [3:0]              fifo_count;
   logic                    overflow;

   drain_collector #(
      .NUM_PE     (NPE),
      .FIFO_DEPTH (DEPTH),
      .DATA_WIDTH (DW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .clear_i      (clear),
      .drain_i      (drain),
      .res_valid_o  (res_valid),
      .res_ready_i  (ready),
      .res_data_o   (res_data),
`ifdef DRAIN_IDX_EN
      .res_idx_o    (res_idx),
`endif
      .fifo_count_o (fifo_count),
      .overflow_o   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   string phase = "init";

   // Reference model: slots, rotating pointer, FIFO as queues
   bit            m_vld [NPE];
   logic [DW-1:0] m_data [NPE];
   int            m_ptr;
   bit            m_ovf;
   logic [DW-1:0] q_data [$];
   int            q_idx [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s/%s at %0t: got %0h expected %0h", phase, name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NPE; i++) begin
         m_vld[i]  = 1'b0;
         m_data[i] = '0;
      end
      m_ptr = 0;
      m_ovf = 1'b0;
      q_data.delete();
      q_idx.delete();
   endtask

   task automatic model_step(input bit clr, input bit rdy, input bit [NPE-1:0] en,
                             input logic [NPE-1:0][DW-1:0] d);
      bit pop;
      int g;
      if (clr) begin
         model_reset();
         return;
      end
      pop = (q_data.size() > 0) && rdy;
      g   = -1;
      if (q_data.size() < DEPTH || pop) begin
         for (int k = 0; k < NPE; k++) begin
            int j;
            j = (m_ptr + k) % NPE;
            if (g < 0 && m_vld[j]) g = j;
         end
      end
      if (pop) begin
         void'(q_data.pop_front());
         void'(q_idx.pop_front());
      end
      if (g >= 0) begin
         q_data.push_back(m_data[g]);
         q_idx.push_back(g);
         m_ptr = (g + 1) % NPE;
      end
      for (int i = 0; i < NPE; i++) begin
         if (en[i]) begin
            if (m_vld[i] && i != g) m_ovf = 1'b1;
            else begin
               m_vld[i]  = 1'b1;
               m_data[i] = d[i];
            end
         end else if (i == g) begin
            m_vld[i] = 1'b0;
         end
      end
   endtask

   task automatic compare_model();
      chk("valid", 32'(res_valid), 32'(q_data.size() > 0));
      chk("data", 32'(res_data), (q_data.size() > 0) ? 32'(q_data[0]) : 32'h0);
      chk("count", 32'(fifo_count), 32'(q_data.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef DRAIN_IDX_EN
      chk("idx", 32'(res_idx), (q_idx.size() > 0) ? 32'(q_idx[0]) : 32'h0);
`endif
   endtask

   // Called at a negedge: drive, clock, advance model, sample at next negedge
   task automatic step(input bit clr, input bit rdy, input bit [NPE-1:0] en,
                       input logic [NPE-1:0][DW-1:0] d);
      clear = clr;
      ready = rdy;
      for (int i = 0; i < NPE; i++) drain[i] = {d[i], en[i]};
      @(posedge clk);
      model_step(clr, rdy, en, d);
      @(negedge clk);
      compare_model();
   endtask

   task automatic idle(input bit rdy);
      step(1'b0, rdy, '0, '0);
   endtask

   typedef struct {
      bit                   clr;
      bit [NPE-1:0]         en;
      logic [NPE-1:0][DW-1:0] d;
      bit                   exp_v;
      logic [DW-1:0]        exp_d;
      int                   exp_c;
   } vec_t;

   vec_t tbl [7];

   initial begin
      logic [NPE-1:0][DW-1:0] d;
      int seq [$];

      // Simultaneous emit from all four PEs: results leave in index order
      tbl[0] = '{clr: 1'b1, en: 4'b0000, d: '0, exp_v: 1'b0, exp_d: 16'd0, exp_c: 0};
      tbl[1] = '{clr: 1'b0, en: 4'b1111, d: {16'd40, 16'd30, 16'd20, 16'd10},
                 exp_v: 1'b0, exp_d: 16'd0, exp_c: 0};
      tbl[2] = '{clr: 1'b0, en: 4'b0000, d: '0, exp_v: 1'b1, exp_d: 16'd10, exp_c: 1};
      tbl[3] = '{clr: 1'b0, en: 4'b0000, d: '0, exp_v: 1'b1, exp_d: 16'd20, exp_c: 1};
      tbl[4] = '{clr: 1'b0, en: 4'b0000, d: '0, exp_v: 1'b1, exp_d: 16'd30, exp_c: 1};
      tbl[5] = '{clr: 1'b0, en: 4'b0000, d: '0, exp_v: 1'b1, exp_d: 16'd40, exp_c: 1};
      tbl[6] = '{clr: 1'b0, en: 4'b0000, d: '0, exp_v: 1'b0, exp_d: 16'd0, exp_c: 0};

      rst_n = 1'b0;
      clear = 1'b0;
      ready = 1'b0;
      drain = '0;
      model_reset();
      #3;
      phase = "reset";
      compare_model();
      @(negedge clk);
      rst_n = 1'b1;

      phase = "table";
      for (int r = 0; r < 7; r++) begin
         step(tbl[r].clr, 1'b1, tbl[r].en, tbl[r].d);
         chk($sformatf("row%0d_valid", r), 32'(res_valid), 32'(tbl[r].exp_v));
         chk($sformatf("row%0d_data", r), 32'(res_data), 32'(tbl[r].exp_d));
         chk($sformatf("row%0d_count", r), 32'(fifo_count), 32'(tbl[r].exp_c));
         chk($sformatf("row%0d_ovf", r), 32'(overflow), 32'h0);
      end

      phase = "single";
      step(1'b1, 1'b1, '0, '0);
      d = '0;
      d[2] = 16'h1234;
      step(1'b0, 1'b1, 4'b0100, d);
      chk("t1_valid", 32'(res_valid), 32'h0);
      idle(1'b1);
      chk("t2_valid", 32'(res_valid), 32'h1);
      chk("t2_data", 32'(res_data), 32'h1234);
`ifdef DRAIN_IDX_EN
      chk("t2_idx", 32'(res_idx), 32'h2);
`endif
      idle(1'b1);
      chk("t3_count", 32'(fifo_count), 32'h0);

      phase = "rr";
      step(1'b1, 1'b1, '0, '0);
      for (int c = 0; c < 14; c++) begin
         d = '0;
         d[0] = {4'h0, 12'(c)};
         d[3] = {4'h3, 12'(c)};
         step(1'b0, 1'b1, 4'b1001, d);
         if (res_valid) seq.push_back(int'(res_data[15:12]));
      end
      chk("rr_len", 32'(seq.size() >= 8), 32'h1);
      for (int k = 0; k < 8 && k < seq.size(); k++)
         chk($sformatf("rr_src%0d", k), 32'(seq[k]), (k % 2 == 0) ? 32'h0 : 32'h3);
      chk("rr_ovf", 32'(overflow), 32'h1);
      idle(1'b1);
      chk("rr_ovf_sticky", 32'(overflow), 32'h1);

      phase = "backpressure";
      step(1'b1, 1'b1, '0, '0);
      for (int c = 0; c < 9; c++) begin
         d = '0;
         d[1] = 16'h4000 + 16'(c);
         step(1'b0, 1'b0, 4'b0010, d);
      end
      idle(1'b0);
      chk("bp_full", 32'(fifo_count), 32'd8);
      chk("bp_head", 32'(res_data), 32'h4000);
      idle(1'b1);
      chk("bp_poppush_count", 32'(fifo_count), 32'd8);
      chk("bp_poppush_head", 32'(res_data), 32'h4001);
      chk("bp_ovf", 32'(overflow), 32'h0);
      for (int c = 0; c < 10; c++) idle(1'b1);
      chk("bp_drained", 32'(fifo_count), 32'd0);

      phase = "overflow";
      step(1'b1, 1'b1, '0, '0);
      for (int c = 0; c < 8; c++) begin
         d = '0;
         d[0] = 16'h5000 + 16'(c);
         step(1'b0, 1'b0, 4'b0001, d);
      end
      idle(1'b0);
      chk("of_full", 32'(fifo_count), 32'd8);
      d = '0;
      d[1] = 16'hAAAA;
      step(1'b0, 1'b0, 4'b0010, d);
      chk("of_first_kept", 32'(overflow), 32'h0);
      d[1] = 16'hBBBB;
      step(1'b0, 1'b0, 4'b0010, d);
      chk("of_second_drop", 32'(overflow), 32'h1);
      step(1'b1, 1'b1, 4'b1111, '1);
      chk("of_clr_count", 32'(fifo_count), 32'h0);
      chk("of_clr_ovf", 32'(overflow), 32'h0);
      chk("of_clr_valid", 32'(res_valid), 32'h0);
      for (int c = 0; c < 3; c++) idle(1'b1);

      phase = "async_reset";
      for (int c = 0; c < 5; c++) begin
         d = '0;
         d[0] = 16'h6000 + 16'(c);
         step(1'b0, 1'b0, 4'b0001, d);
      end
      idle(1'b0);
      chk("ar_count5", 32'(fifo_count), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(res_valid), 32'h0);
      chk("ar_data", 32'(res_data), 32'h0);
      chk("ar_count", 32'(fifo_count), 32'h0);
      chk("ar_ovf", 32'(overflow), 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) idle(1'b1);

      phase = "random";
      for (int c = 0; c < 600; c++) begin
         bit [NPE-1:0] en;
         bit rdy;
         bit clr;
         en = NPE'($urandom) & NPE'($urandom);
         if (c % 200 < 100) rdy = ($urandom_range(0, 3) != 0);
         else rdy = ($urandom_range(0, 3) == 0);
         clr = ($urandom_range(0, 79) == 0);
         for (int i = 0; i < NPE; i++) d[i] = DW'($urandom);
         step(clr, rdy, en, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
